// File: rtl/ps2_host_transmitter.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, 8 data bits,
// odd parity and stop, then the device ack, with a watchdog over the device-clocked part.
module ps2_host_transmitter #(
    parameter int ClkFrequency = 100_000_000,
    parameter int InhibitUs    = 100,
    parameter int RequestUs    = 2,
    parameter int TimeoutUs    = 15000,
    parameter int FilterLen    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       txStart,
    input  logic [7:0] txData,
    input  logic       ps2ClkIn,
    input  logic       ps2DataIn,
    output logic       ps2ClkOe,
    output logic       ps2DataOe,
    output logic       txBusy,
    output logic       txDone,
    output logic       txError,
    output logic       rxInhibit
);
    localparam int CyclesPerUs   = ClkFrequency / 1_000_000;
    localparam int InhibitCycles = CyclesPerUs * InhibitUs;
    localparam int RequestCycles = CyclesPerUs * RequestUs;
    localparam int TimeoutCycles = CyclesPerUs * TimeoutUs;
    localparam int TmrMax        = (InhibitCycles > RequestCycles) ? InhibitCycles : RequestCycles;
    localparam int TmrW          = $clog2(TmrMax) + 1;
    localparam int WdgW          = $clog2(TimeoutCycles) + 1;
    localparam int FltW          = $clog2(FilterLen) + 1;
    localparam logic [TmrW-1:0] InhibitLast = TmrW'(InhibitCycles - 1);
    localparam logic [TmrW-1:0] RequestLast = TmrW'(RequestCycles - 1);
    localparam logic [WdgW-1:0] TimeoutLast = WdgW'(TimeoutCycles - 1);
    localparam logic [FltW-1:0] FilterLast  = FltW'(FilterLen - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQUEST, S_SHIFT, S_ACK, S_WAIT_IDLE, S_DONE
    } state_t;

    logic [1:0]      clk_sync_q, data_sync_q;
    logic            clk_filt_q, clk_filt_prev_q;
    logic [FltW-1:0] flt_cnt_q;
    logic            fall;

    // The filtered clock flips only after FilterLen consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q      <= '1;
            data_sync_q     <= '1;
            clk_filt_q      <= 1'b1;
            clk_filt_prev_q <= 1'b1;
            flt_cnt_q       <= '0;
        end else begin
            clk_sync_q      <= {clk_sync_q[0], ps2ClkIn};
            data_sync_q     <= {data_sync_q[0], ps2DataIn};
            clk_filt_prev_q <= clk_filt_q;
            if (clk_sync_q[1] == clk_filt_q) begin
                flt_cnt_q <= '0;
            end else if (flt_cnt_q == FilterLast) begin
                clk_filt_q <= clk_sync_q[1];
                flt_cnt_q  <= '0;
            end else begin
                flt_cnt_q <= flt_cnt_q + 1'b1;
            end
        end
    end

    assign fall = clk_filt_prev_q & ~clk_filt_q;

    state_t          state_q, state_d;
    logic [7:0]      byte_q, byte_d;
    logic            parity_q, parity_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [TmrW-1:0] tmr_q, tmr_d;
    logic [WdgW-1:0] wdg_q, wdg_d;
    logic            err_q, err_d;
    logic            clk_oe_q, clk_oe_d;
    logic            data_oe_q, data_oe_d;
    logic            wdg_expired;

    assign wdg_expired = (wdg_q == TimeoutLast);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            byte_q    <= '0;
            parity_q  <= 1'b0;
            bit_cnt_q <= '0;
            tmr_q     <= '0;
            wdg_q     <= '0;
            err_q     <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            byte_q    <= byte_d;
            parity_q  <= parity_d;
            bit_cnt_q <= bit_cnt_d;
            tmr_q     <= tmr_d;
            wdg_q     <= wdg_d;
            err_q     <= err_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        byte_d    = byte_q;
        parity_d  = parity_q;
        bit_cnt_d = bit_cnt_q;
        tmr_d     = tmr_q;
        wdg_d     = wdg_q;
        err_d     = err_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        case (state_q)
            S_IDLE: begin
                if (txStart) begin
                    byte_d    = txData;
                    parity_d  = ~^txData;
                    err_d     = 1'b0;
                    tmr_d     = '0;
                    clk_oe_d  = 1'b1;
                    data_oe_d = 1'b0;
                    state_d   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                tmr_d = tmr_q + 1'b1;
                if (tmr_q == InhibitLast) begin
                    tmr_d     = '0;
                    data_oe_d = 1'b1;
                    state_d   = S_REQUEST;
                end
            end
            S_REQUEST: begin
                tmr_d = tmr_q + 1'b1;
                if (tmr_q == RequestLast) begin
                    clk_oe_d  = 1'b0;
                    bit_cnt_d = '0;
                    wdg_d     = '0;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                wdg_d = wdg_q + 1'b1;
                if (wdg_expired) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = S_DONE;
                end else if (fall) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q < 4'd8) begin
                        data_oe_d = ~byte_q[bit_cnt_q[2:0]];
                    end else if (bit_cnt_q == 4'd8) begin
                        data_oe_d = ~parity_q;
                    end else begin
                        data_oe_d = 1'b0;
                        state_d   = S_ACK;
                    end
                end
            end
            S_ACK: begin
                wdg_d = wdg_q + 1'b1;
                // An ack edge landing on the expiry cycle still counts as the answer.
                if (fall) begin
                    err_d   = data_sync_q[1];
                    state_d = S_WAIT_IDLE;
                end else if (wdg_expired) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_WAIT_IDLE: begin
                wdg_d = wdg_q + 1'b1;
                if (clk_filt_q && data_sync_q[1]) begin
                    state_d = S_DONE;
                end else if (wdg_expired) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
            end
        endcase
    end

    assign ps2ClkOe  = clk_oe_q;
    assign ps2DataOe = data_oe_q;
    assign txBusy    = (state_q != S_IDLE);
    assign rxInhibit = (state_q != S_IDLE);
    assign txDone    = (state_q == S_DONE);
    assign txError   = (state_q == S_DONE) & err_q;
endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Bench for ps2_host_transmitter: a PS/2 device model on open-drain lines reads each frame
// and answers ack/NACK; frame contents are predicted from the byte alone.
module tb_ps2_host_transmitter;
    localparam int InhibitCyc = 100;
    localparam int RequestCyc = 2;
    localparam int TimeoutCyc = 500;

    logic       clk = 1'b0;
    logic       rst;
    logic       txStart;
    logic [7:0] txData;
    logic       ps2ClkIn, ps2DataIn;
    logic       ps2ClkOe, ps2DataOe;
    logic       txBusy, txDone, txError, rxInhibit;
    logic       dev_clk, dev_data, glitch;
    int         checks = 0;
    int         errors = 0;
    int         rxi_bad = 0;

    ps2_host_transmitter #(
        .ClkFrequency(1_000_000),
        .InhibitUs   (100),
        .RequestUs   (2),
        .TimeoutUs   (500),
        .FilterLen   (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .txStart  (txStart),
        .txData   (txData),
        .ps2ClkIn (ps2ClkIn),
        .ps2DataIn(ps2DataIn),
        .ps2ClkOe (ps2ClkOe),
        .ps2DataOe(ps2DataOe),
        .txBusy   (txBusy),
        .txDone   (txDone),
        .txError  (txError),
        .rxInhibit(rxInhibit)
    );

    always #5 clk = ~clk;

    // Open-drain wiring: either side can pull a line low.
    assign ps2ClkIn  = dev_clk & ~ps2ClkOe & ~glitch;
    assign ps2DataIn = dev_data & ~ps2DataOe;

    always @(negedge clk) begin
        if (!rst && (rxInhibit !== txBusy)) rxi_bad++;
    end

    function automatic logic model_bit(input logic [7:0] d, input int k);
        if (k >= 1 && k <= 8) return d[k-1];
        if (k == 9) return ($countones(d) % 2 == 0);
        return 1'b1;
    endfunction

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_tx(input logic [7:0] d);
        txData  = d;
        txStart = 1'b1;
        @(negedge clk);
        txStart = 1'b0;
        txData  = 8'($urandom);
    endtask

    task automatic preamble(input string tag);
        int n;
        n = 0;
        while (ps2ClkOe === 1'b1 && ps2DataOe === 1'b0 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != InhibitCyc) begin
            errors++;
            $display("FAIL %s inhibit_len: got %0d cycles expected %0d", tag, n, InhibitCyc);
        end
        n = 0;
        while (ps2ClkOe === 1'b1 && ps2DataOe === 1'b1 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != RequestCyc) begin
            errors++;
            $display("FAIL %s request_len: got %0d cycles expected %0d", tag, n, RequestCyc);
        end
        checks++;
        if (ps2ClkOe !== 1'b0 || ps2DataOe !== 1'b1 || rxInhibit !== 1'b1) begin
            errors++;
            $display("FAIL %s release: clkoe=%b dataoe=%b rxinh=%b expected 0 1 1",
                     tag, ps2ClkOe, ps2DataOe, rxInhibit);
        end
    endtask

    task automatic dev_clocks(input logic [7:0] d, input int first, input int last,
                              input int pulse_at, input int glitch_at, input string tag);
        logic got_b, exp_b;
        for (int k = first; k <= last; k++) begin
            if (k == pulse_at) begin
                txData  = 8'h55;
                txStart = 1'b1;
                @(negedge clk);
                txStart = 1'b0;
            end
            if (k == glitch_at) begin
                glitch = 1'b1;
                @(negedge clk);
                glitch = 1'b0;
                wait_n(8);
            end
            dev_clk = 1'b0;
            wait_n(20);
            dev_clk = 1'b1;
            got_b = ps2DataIn;
            exp_b = model_bit(d, k);
            checks++;
            if (got_b !== exp_b) begin
                errors++;
                $display("FAIL %s bit%0d: line %b expected %b", tag, k, got_b, exp_b);
            end
            wait_n(20);
        end
    endtask

    task automatic ack_finish(input logic nack, input string tag);
        int i;
        dev_data = nack;
        wait_n(5);
        dev_clk = 1'b0;
        wait_n(20);
        dev_clk = 1'b1;
        i = 0;
        while (txDone !== 1'b1 && i < 200) begin
            @(negedge clk);
            i++;
            if (i == 5) dev_data = 1'b1;
        end
        dev_data = 1'b1;
        checks++;
        if (i >= 200) begin
            errors++;
            $display("FAIL %s done_timeout: txDone=%b after %0d cycles expected 1", tag, txDone, i);
            return;
        end
        checks++;
        if (txError !== nack) begin
            errors++;
            $display("FAIL %s txError: got %b expected %b", tag, txError, nack);
        end
        checks++;
        if (ps2ClkOe !== 1'b0 || ps2DataOe !== 1'b0 || txBusy !== 1'b1 || rxInhibit !== 1'b1) begin
            errors++;
            $display("FAIL %s done_state: clkoe=%b dataoe=%b busy=%b rxinh=%b expected 0 0 1 1",
                     tag, ps2ClkOe, ps2DataOe, txBusy, rxInhibit);
        end
        @(negedge clk);
        checks++;
        if (txBusy !== 1'b0 || txDone !== 1'b0 || txError !== 1'b0 || rxInhibit !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done: busy=%b done=%b err=%b rxinh=%b expected 0 0 0 0",
                     tag, txBusy, txDone, txError, rxInhibit);
        end
        wait_n(10);
    endtask

    task automatic do_transfer(input logic [7:0] d, input logic nack, input int pulse_at,
                               input string tag);
        start_tx(d);
        preamble(tag);
        wait_n(20);
        dev_clocks(d, 1, 10, pulse_at, 0, tag);
        ack_finish(nack, tag);
        $display("xfer %s: data=%02h nack=%b", tag, d, nack);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_n(4);
        checks++;
        if ({ps2ClkOe, ps2DataOe, txBusy, txDone, txError, rxInhibit} !== 6'b0) begin
            errors++;
            $display("FAIL reset outputs: got %b expected 000000",
                     {ps2ClkOe, ps2DataOe, txBusy, txDone, txError, rxInhibit});
        end
        rst = 1'b0;
        wait_n(10);
        checks++;
        if (txBusy !== 1'b0 || ps2ClkOe !== 1'b0) begin
            errors++;
            $display("FAIL reset idle: busy=%b clkoe=%b expected 0 0", txBusy, ps2ClkOe);
        end
        $display("xfer reset: outputs checked");
    endtask

    task automatic test_basic_ack();
        do_transfer(8'hED, 1'b0, 0, "basic_ED");
    endtask

    task automatic test_parity();
        do_transfer(8'h01, 1'b0, 0, "parity_01");
        do_transfer(8'hFF, 1'b0, 0, "parity_FF");
    endtask

    task automatic test_nack();
        do_transfer(8'hF4, 1'b1, 0, "nack_F4");
    endtask

    task automatic test_timeout();
        start_tx(8'hFF);
        preamble("timeout");
        wait_n(TimeoutCyc - 1);
        checks++;
        if (txDone !== 1'b0 || ps2DataOe !== 1'b1) begin
            errors++;
            $display("FAIL timeout early: done=%b dataoe=%b expected 0 1", txDone, ps2DataOe);
        end
        @(negedge clk);
        checks++;
        if (txDone !== 1'b1 || txError !== 1'b1 || ps2ClkOe !== 1'b0 || ps2DataOe !== 1'b0) begin
            errors++;
            $display("FAIL timeout expire: done=%b err=%b clkoe=%b dataoe=%b expected 1 1 0 0",
                     txDone, txError, ps2ClkOe, ps2DataOe);
        end
        @(negedge clk);
        checks++;
        if (txBusy !== 1'b0 || txDone !== 1'b0) begin
            errors++;
            $display("FAIL timeout after: busy=%b done=%b expected 0 0", txBusy, txDone);
        end
        wait_n(10);
        $display("xfer timeout: data=ff no device clocks");
    endtask

    task automatic test_ignore_restart();
        int busy_cycles;
        do_transfer(8'hC6, 1'b0, 5, "restart_C6");
        busy_cycles = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (txBusy === 1'b1 || ps2ClkOe === 1'b1) busy_cycles++;
        end
        checks++;
        if (busy_cycles != 0) begin
            errors++;
            $display("FAIL restart second_xfer: busy cycles %0d expected 0", busy_cycles);
        end
    endtask

    task automatic test_reset_mid_transfer();
        start_tx(8'h2C);
        preamble("rstmid");
        wait_n(20);
        dev_clocks(8'h2C, 1, 4, 0, 3, "rstmid");
        dev_clk = 1'b0;
        wait_n(8);
        checks++;
        if (ps2DataOe !== 1'b1) begin
            errors++;
            $display("FAIL rstmid bit5_drive: dataoe=%b expected 1", ps2DataOe);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({ps2ClkOe, ps2DataOe, txBusy, rxInhibit} !== 4'b0) begin
            errors++;
            $display("FAIL rstmid outputs: clkoe,dataoe,busy,rxinh=%b expected 0000",
                     {ps2ClkOe, ps2DataOe, txBusy, rxInhibit});
        end
        wait_n(12);
        dev_clk = 1'b1;
        wait_n(40);
        $display("xfer rstmid: aborted at fall 5");
        do_transfer(8'hF4, 1'b0, 0, "after_rst_F4");
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       nk;
        for (int r = 0; r < 6; r++) begin
            d  = 8'($urandom_range(0, 255));
            nk = 1'($urandom_range(0, 1));
            do_transfer(d, nk, 0, $sformatf("rand%0d", r));
        end
    endtask

    task automatic test_rx_inhibit();
        checks++;
        if (rxi_bad != 0) begin
            errors++;
            $display("FAIL rxinhibit_track: %0d cycles differing from busy, expected 0", rxi_bad);
        end
    endtask

    initial begin
        rst      = 1'b1;
        txStart  = 1'b0;
        txData   = 8'h00;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        glitch   = 1'b0;
        test_reset();
        test_basic_ack();
        test_parity();
        test_nack();
        test_timeout();
        test_ignore_restart();
        test_reset_mid_transfer();
        test_random();
        test_rx_inhibit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "bench timeout");
    end
endmodule

// File: doc/ps2_host_transmitter.md
Name: ps2_host_transmitter

Overview:
Host-to-device PS/2 transmitter. It sends one command byte (for example 0xED set-LEDs, 0xF4 enable, 0xFF reset) from the console logic to the keyboard over the shared open-drain PS/2 clock and data lines. It sits beside the existing PS/2 receiver in the keyboard controller. While it is busy it tells the receiver to ignore line activity (receiver rx_en = ~rxInhibit).

Parameters:
ClkFrequency, 100_000_000, system clock in Hz.
InhibitUs, 100, time the host holds the PS/2 clock low before a request-to-send.
RequestUs, 2, time data and clock are both held low before the clock is released.
TimeoutUs, 15000, watchdog from clock release until the line returns idle after ack.
FilterLen, 8, consecutive equal samples needed to accept a new PS/2 clock level.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
txStart  in  1  1-cycle request; sampled only in IDLE
txData  in  8  byte to send; latched when txStart is accepted
ps2ClkIn  in  1  raw PS/2 clock pin level (asynchronous)
ps2DataIn  in  1  raw PS/2 data pin level (asynchronous)
ps2ClkOe  out  1  1 = drive PS/2 clock low, 0 = release
ps2DataOe  out  1  1 = drive PS/2 data low, 0 = release
txBusy  out  1  high from txStart acceptance until the cycle after txDone
txDone  out  1  1-cycle pulse at end of a transfer (success or failure)
txError  out  1  1-cycle pulse coincident with txDone on NACK or timeout
rxInhibit  out  1  high in every state except IDLE

Behaviour:
- Reset (synchronous): all outputs 0, state IDLE, counters cleared, filters preset to 1. Reset mid-transfer releases both lines on the next edge.
- Input conditioning:
  - Both pins pass through a 2-FF synchronizer.
  - The clock pin is also filtered: the filtered level changes only after FilterLen identical synchronized samples.
  - fall = filtered clock goes 1 -> 0 (1-cycle strobe).
  - Data is sampled from the synchronized (not filtered) value.
- Cycle counts: InhibitCycles = ClkFrequency/1_000_000*InhibitUs; RequestCycles and TimeoutCycles are derived the same way.
- States:
  - IDLE: lines released, txBusy=0. On txStart: latch txData, compute parity = ~^txData (odd parity), go to INHIBIT.
  - INHIBIT: ClkOe=1, DataOe=0 for InhibitCycles, then go to REQUEST.
  - REQUEST: ClkOe=1, DataOe=1 (start bit) for RequestCycles. Then ClkOe=0, clear bit counter and watchdog, go to SHIFT.
  - SHIFT: DataOe is held from the previous step. On each fall, increment bitCnt (1..10):
    - falls 1-8: DataOe = ~txData[bitCnt-1] (LSB first).
    - fall 9: DataOe = ~parity.
    - fall 10: DataOe = 0 (stop bit, line released); go to ACK.
  - ACK: on fall 11, sample data. 0 = ack; 1 = NACK, which sets an error flag. Go to WAIT_IDLE.
  - WAIT_IDLE: wait until filtered clock = 1 and synchronized data = 1. Then go to DONE.
  - DONE: txDone=1 and txError=flag for one cycle, then IDLE. txBusy falls in the first IDLE cycle.
- Watchdog: counts from entry to SHIFT through WAIT_IDLE. On reaching TimeoutCycles: release both lines, set the error flag, go to DONE.
- Host never drives a line high. ClkOe is never 1 in SHIFT, ACK or WAIT_IDLE.
- txStart while txBusy=1 is ignored: no queueing, txData not re-latched.
- fall strobes outside SHIFT/ACK are ignored.
- Simultaneous watchdog expiry and fall 11 in ACK: the ack sample wins, and the flag reflects the ack value.

Test Plan:
All scenarios use ClkFrequency=1_000_000 (1 cycle/us), FilterLen=2, TimeoutUs=500. The device model clocks at a 40-cycle period, and the bench checks data on each rising edge.
1. txStart with txData=0xED, device acks → ClkOe high for exactly 100 cycles, then DataOe high with ClkOe for 2. Device reads bits 1,0,1,1,0,1,1,1, parity 1, stop 1. Then txDone=1, txError=0; rxInhibit high throughout.
2. txData=0x01 → parity bit read 0 (DataOe=1 after fall 9). txData=0xFF → parity 1; both end with txDone and txError=0.
3. Device holds data high at clock 11 (NACK) → txDone=1, txError=1; lines released; txBusy=0 on the next cycle.
4. Device never clocks after release → exactly 500 cycles after entering SHIFT, ClkOe=DataOe=0 and txDone=txError=1.
5. txStart pulsed again mid-SHIFT with txData=0x55 → ignored; the transfer completes with the original byte and no second transfer follows.
6. rst asserted at fall 5, plus a 1-cycle glitch on the clock pin → glitch causes no bitCnt advance. Next cycle after rst: ClkOe=DataOe=txBusy=rxInhibit=0, and a fresh 0xF4 transfer then succeeds.
